fb_arbiter: RTL and testbench
=============================

// Module: fb_arbiter
// PURPOSE
//  Shares the single-port synchronous framebuffer RAM (512 x 16 bit, 1 px/bit) among three users:
//  the display scan-out reader, the CHIP-8 CPU (DXYN read-modify-write, 00E0), and an internal
//  clear engine. Display reads are never stalled. The clear engine and CPU use idle RAM cycles.
//  Sits between the display block / CPU core and the framebuffer RAM instance.
// PARAMETERS
//  ADDR_W       9    framebuffer word address width
//  DATA_W       16   framebuffer word width
//  HIRES_WORDS  512  words cleared in hires mode (128x64/16)
//  LORES_WORDS  128  words cleared in lores mode (64x32/16)
// PORTS
//  clk         in   1       system clock, all logic rising-edge
//  rst_n       in   1       asynchronous active-low reset
//  disp_req    in   1       display wants a read this cycle
//  disp_addr   in   ADDR_W  display read address
//  disp_data   out  DATA_W  read data; valid when disp_valid=1
//  disp_valid  out  1       high the cycle after a display grant
//  cpu_req     in   1       CPU access request; hold fields stable until cpu_ack
//  cpu_we      in   1       1=write, 0=read
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_rdata   out  DATA_W  CPU read data; valid with cpu_ack on reads
//  cpu_ack     out  1       1-cycle pulse: access complete
//  clr_start   in   1       1-cycle pulse: start framebuffer clear
//  clr_hires   in   1       sampled at clr_start: 1=HIRES_WORDS, 0=LORES_WORDS
//  clr_busy    out  1       clear in progress
//  ram_addr    out  ADDR_W  RAM address (combinational from grant)
//  ram_we      out  1       RAM write enable
//  ram_wdata   out  DATA_W  RAM write data
//  ram_rdata   in   DATA_W  RAM read data, 1-cycle synchronous latency
// BEHAVIOUR
//  - Reset (async, rst_n=0): disp_valid=0, cpu_ack=0, clr_busy=0, owner tag=NONE, clear counter=0.
//    disp_data/cpu_rdata pass ram_rdata (don't care when not valid). Reset mid-clear aborts it;
//    RAM contents are undefined after a partial clear.
//  - Fixed priority per cycle: DISP > CLR > CPU. Grant is combinational from current requests.
//    ram_* driven by the winner; ram_we=0 when no grant or DISP grant.
//  - Owner tag registered each cycle (NONE/DISP/CPU/CLR). Cycle N+1 after a grant:
//    DISP -> disp_valid=1, disp_data=ram_rdata; CPU -> cpu_ack=1, cpu_rdata=ram_rdata.
//  - CPU handshake: no CPU grant in a cycle where cpu_ack is high. CPU may keep cpu_req high in
//    the ack cycle with new fields; it is treated as a new request. Max rate: 1 access/2 cycles.
//  - Clear FSM states: IDLE, RUN. IDLE + clr_start -> RUN. Latch limit = clr_hires ? HIRES_WORDS-1
//    : LORES_WORDS-1. Counter resets to 0. In RUN, each cycle without disp_req: write 0 at counter,
//    then increment. After the write at limit -> IDLE. clr_busy=1 exactly in RUN.
//  - clr_start while RUN is ignored. The limit is not re-latched.
//  - CPU requests pending while RUN wait until IDLE. This keeps 00E0 ordering before subsequent DXYN.
//  - CPU access granted the same cycle clr_start arrives completes normally. Clear begins next cycle.
//  - Counter width ADDR_W. Wrap never occurs because RUN ends at the limit.
//  - disp_req high every cycle: CPU and clear make no progress. This is legal; blanking supplies slots.
// STRUCTURE
//  - Shared header fb_defs.vh: FB_ADDR_W, FB_DATA_W, FB_HIRES_WORDS, FB_LORES_WORDS,
//    owner encodings OWN_NONE=2'd0, OWN_DISP=2'd1, OWN_CPU=2'd2, OWN_CLR=2'd3.
//  - Sub-module fb_clear_engine: IDLE/RUN FSM, limit latch, address counter.
//    Its interface: step(in, =grant), addr(out), busy(out).
//  - Top level: priority mux, owner tag register, ack/valid generation.
// TESTING
//  1 Display only: disp_req=1 addr 0..7 on consecutive cycles, RAM preloaded word=addr ->
//    disp_valid every cycle from cycle 1, disp_data 0..7 in order.
//  2 CPU write 0xA5A5 @0x010, then read @0x010, disp_req=0 -> ack 1 cycle after each grant.
//    Read returns 0xA5A5. Second grant no earlier than 2 cycles after the first.
//  3 Conflict: disp_req=1 for 4 cycles while cpu_req=1 -> no CPU grant during those 4 cycles.
//    cpu_ack in cycle 6. Display data is uninterrupted.
//  4 Lores clear: clr_start, clr_hires=0, no display -> clr_busy high for 128 cycles.
//    Words 0..127 are 0, word 128 is untouched. Hires: 512 cycles, all words 0.
//  5 Clear with display interleave (disp_req every other cycle) and a cpu_req queued ->
//    clr_busy lasts 2x words. cpu_ack comes only after clr_busy falls. Repeated clr_start is ignored.
//  6 rst_n low mid-clear (counter=40) -> clr_busy, disp_valid, cpu_ack immediately 0.
//    After release, next clr_start restarts at address 0.

Source files
------------

// File: rtl/fb_arbiter_pkg.sv
// Shared framebuffer geometry, owner tags and clear-engine states for the
// framebuffer arbiter.
package fb_arbiter_pkg;

    localparam int FB_ADDR_W      = 9;
    localparam int FB_DATA_W      = 16;
    localparam int FB_HIRES_WORDS = 512;
    localparam int FB_LORES_WORDS = 128;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_CLR  = 2'd3
    } owner_t;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/fb_arbiter_clear_engine.sv
// Framebuffer clear engine: walks word addresses 0..limit, writing zero on
// every cycle the arbiter hands it the RAM.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   CLR_IDLE | no clear in progress, waiting for start
//   CLR_RUN  | clearing; addr is the next word to write, busy=1
module fb_clear_engine
    import fb_arbiter_pkg::*;
#(
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int HIRES_WORDS = FB_HIRES_WORDS,
    parameter int LORES_WORDS = FB_LORES_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hires,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] HIRES_LAST = ADDR_W'(HIRES_WORDS - 1);
    localparam logic [ADDR_W-1:0] LORES_LAST = ADDR_W'(LORES_WORDS - 1);

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] limit, limit_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLR_IDLE;
            limit <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            limit <= limit_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        limit_nxt = limit;
        cnt_nxt   = cnt;
        case (state)
            CLR_IDLE: begin
                if (start) begin
                    state_nxt = CLR_RUN;
                    limit_nxt = hires ? HIRES_LAST : LORES_LAST;
                    cnt_nxt   = '0;
                end
            end
            CLR_RUN: begin
                // Holding the counter on the final word keeps it from wrapping.
                if (step) begin
                    if (cnt == limit) state_nxt = CLR_IDLE;
                    else              cnt_nxt   = cnt + ADDR_W'(1);
                end
            end
            default: state_nxt = CLR_IDLE;
        endcase
    end

    assign addr = cnt;
    assign busy = (state == CLR_RUN);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: display scan-out always wins, the clear
// engine and CPU share whatever cycles the display leaves idle.
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int DATA_W      = FB_DATA_W,
    parameter int HIRES_WORDS = FB_HIRES_WORDS,
    parameter int LORES_WORDS = FB_LORES_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              clr_start,
    input  logic              clr_hires,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] clr_addr;

    fb_clear_engine #(
        .ADDR_W      (ADDR_W),
        .HIRES_WORDS (HIRES_WORDS),
        .LORES_WORDS (LORES_WORDS)
    ) u_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .start (clr_start),
        .hires (clr_hires),
        .step  (owner_d == OWN_CLR),
        .addr  (clr_addr),
        .busy  (clr_busy)
    );

    // A pending CPU request is locked out both during a clear and in its own
    // ack cycle, so the CPU never sees a stale ack for a fresh request.
    always_comb begin
        owner_d   = OWN_NONE;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (disp_req) begin
            owner_d  = OWN_DISP;
            ram_addr = disp_addr;
        end else if (clr_busy) begin
            owner_d  = OWN_CLR;
            ram_addr = clr_addr;
            ram_we   = 1'b1;
        end else if (cpu_req && !cpu_ack) begin
            owner_d   = OWN_CPU;
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) owner_q <= OWN_NONE;
        else        owner_q <= owner_d;
    end

    assign disp_valid = (owner_q == OWN_DISP);
    assign cpu_ack    = (owner_q == OWN_CPU);
    assign disp_data  = ram_rdata;
    assign cpu_rdata  = ram_rdata;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter with a behavioural framebuffer RAM and a
// reference memory image maintained from the arbitration rules.
module tb_fb_arbiter;
    import fb_arbiter_pkg::*;

    localparam int AW = FB_ADDR_W;
    localparam int DW = FB_DATA_W;
    localparam int NW = FB_HIRES_WORDS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          disp_req, disp_valid, cpu_req, cpu_we, cpu_ack;
    logic          clr_start, clr_hires, clr_busy, ram_we;
    logic [AW-1:0] disp_addr, cpu_addr, ram_addr;
    logic [DW-1:0] disp_data, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;

    logic [DW-1:0] mem     [NW];
    logic [DW-1:0] ref_mem [NW];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    fb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .clr_start  (clr_start),
        .clr_hires  (clr_hires),
        .clr_busy   (clr_busy),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Read-first synchronous RAM with a bench-side load port.
    always_ff @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ld_en)       mem[ld_addr]  <= ld_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_req  = 1'b0;
        disp_addr = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        clr_start = 1'b0;
        clr_hires = 1'b0;
    endtask

    task automatic load_word(input int a, input logic [DW-1:0] d);
        ld_en   = 1'b1;
        ld_addr = AW'(a);
        ld_data = d;
        ref_mem[a] = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic preload_random();
        for (int a = 0; a < NW; a++) load_word(a, DW'($urandom_range(1, 65535)));
    endtask

    function automatic int mem_mismatches();
        int n = 0;
        for (int a = 0; a < NW; a++) if (mem[a] !== ref_mem[a]) n++;
        return n;
    endfunction

    task automatic test_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        #2;
        checks++; if (disp_valid !== 1'b0) $display("FAIL reset_disp_valid: got %b want 0", disp_valid); else passes++;
        checks++; if (cpu_ack !== 1'b0) $display("FAIL reset_cpu_ack: got %b want 0", cpu_ack); else passes++;
        checks++; if (clr_busy !== 1'b0) $display("FAIL reset_clr_busy: got %b want 0", clr_busy); else passes++;
        checks++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we: got %b want 0", ram_we); else passes++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_display();
        preload_random();
        for (int i = 0; i < 8; i++) load_word(i, DW'(i));
        for (int i = 0; i < 8; i++) begin
            disp_req  = 1'b1;
            disp_addr = AW'(i);
            #1;
            checks++; if ({ram_we, ram_addr} !== {1'b0, AW'(i)}) $display("FAIL disp_ram_port: got we=%b addr=%0h want we=0 addr=%0h", ram_we, ram_addr, i); else passes++;
            tick();
            checks++; if (disp_valid !== 1'b1) $display("FAIL disp_valid_%0d: got %b want 1", i, disp_valid); else passes++;
            checks++; if (disp_data !== DW'(i)) $display("FAIL disp_data_%0d: got %0h want %0h", i, disp_data, i); else passes++;
        end
        disp_req = 1'b0;
        tick();
        checks++; if (disp_valid !== 1'b0) $display("FAIL disp_valid_drop: got %b want 0", disp_valid); else passes++;
    endtask

    task automatic test_cpu_rw();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h010; cpu_wdata = 16'hA5A5;
        #1;
        checks++; if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 9'h010, 16'hA5A5}) $display("FAIL cpu_wr_port: got we=%b addr=%0h data=%0h want 1/10/a5a5", ram_we, ram_addr, ram_wdata); else passes++;
        tick();
        ref_mem[16] = 16'hA5A5;
        checks++; if (cpu_ack !== 1'b1) $display("FAIL cpu_wr_ack: got %b want 1", cpu_ack); else passes++;
        cpu_we = 1'b0; cpu_wdata = '0;
        tick();
        checks++; if (cpu_ack !== 1'b0) $display("FAIL cpu_ack_cycle_grant: got %b want 0", cpu_ack); else passes++;
        tick();
        checks++; if (cpu_ack !== 1'b1) $display("FAIL cpu_rd_ack: got %b want 1", cpu_ack); else passes++;
        checks++; if (cpu_rdata !== 16'hA5A5) $display("FAIL cpu_rd_data: got %0h want a5a5", cpu_rdata); else passes++;
        cpu_req = 1'b0;
        tick();
        checks++; if (cpu_ack !== 1'b0) $display("FAIL cpu_ack_pulse: got %b want 0", cpu_ack); else passes++;
    endtask

    task automatic test_conflict();
        int a;
        a = int'($urandom_range(200, NW - 1));
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(a);
        for (int k = 0; k < 4; k++) begin
            disp_req  = 1'b1;
            disp_addr = AW'(k);
            tick();
            checks++; if (cpu_ack !== 1'b0) $display("FAIL conflict_no_ack_%0d: got %b want 0", k, cpu_ack); else passes++;
            checks++; if ({disp_valid, disp_data} !== {1'b1, ref_mem[k]}) $display("FAIL conflict_disp_%0d: got v=%b d=%0h want 1/%0h", k, disp_valid, disp_data, ref_mem[k]); else passes++;
        end
        disp_req = 1'b0;
        tick();
        checks++; if (cpu_ack !== 1'b1) $display("FAIL conflict_ack_cycle6: got %b want 1", cpu_ack); else passes++;
        checks++; if (cpu_rdata !== ref_mem[a]) $display("FAIL conflict_rdata: got %0h want %0h", cpu_rdata, ref_mem[a]); else passes++;
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_random_traffic();
        logic          exp_ack, nxt_ack, d, rd;
        logic [DW-1:0] exp_disp, exp_rd;
        exp_ack = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (exp_ack || !cpu_req) begin
                cpu_req   = exp_ack ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = AW'($urandom_range(0, NW - 1));
                cpu_wdata = DW'($urandom_range(0, 65535));
            end
            disp_req  = 1'($urandom_range(0, 1));
            disp_addr = AW'($urandom_range(0, NW - 1));
            d        = disp_req;
            exp_disp = ref_mem[disp_addr];
            nxt_ack  = !disp_req && cpu_req && !exp_ack;
            rd       = nxt_ack && !cpu_we;
            exp_rd   = ref_mem[cpu_addr];
            if (nxt_ack && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            tick();
            checks++; if (disp_valid !== d) $display("FAIL rnd_disp_valid c=%0d: got %b want %b", c, disp_valid, d); else passes++;
            if (d) begin
                checks++; if (disp_data !== exp_disp) $display("FAIL rnd_disp_data c=%0d: got %0h want %0h", c, disp_data, exp_disp); else passes++;
            end
            checks++; if (cpu_ack !== nxt_ack) $display("FAIL rnd_cpu_ack c=%0d: got %b want %b", c, cpu_ack, nxt_ack); else passes++;
            if (rd) begin
                checks++; if (cpu_rdata !== exp_rd) $display("FAIL rnd_cpu_rdata c=%0d: got %0h want %0h", c, cpu_rdata, exp_rd); else passes++;
            end
            exp_ack = nxt_ack;
        end
        idle_inputs();
        tick();
        tick();
        checks++; if (mem_mismatches() != 0) $display("FAIL rnd_mem_image: got %0d bad words want 0", mem_mismatches()); else passes++;
    endtask

    task automatic test_clear(input logic hires);
        int n, words;
        words = hires ? FB_HIRES_WORDS : FB_LORES_WORDS;
        preload_random();
        clr_hires = hires;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        n = 0;
        while (clr_busy && n < 2000) begin
            n++;
            tick();
        end
        for (int a = 0; a < words; a++) ref_mem[a] = '0;
        checks++; if (n != words) $display("FAIL clear_busy_len hires=%b: got %0d want %0d", hires, n, words); else passes++;
        checks++; if (mem_mismatches() != 0) $display("FAIL clear_mem hires=%b: got %0d bad words want 0", hires, mem_mismatches()); else passes++;
        if (!hires) begin
            checks++; if (mem[128] !== ref_mem[128]) $display("FAIL clear_word128: got %0h want %0h", mem[128], ref_mem[128]); else passes++;
        end
    endtask

    task automatic test_clear_interleave();
        int n, acks;
        logic d;
        logic [AW-1:0] a;
        preload_random();
        clr_hires = 1'b0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h100; cpu_wdata = 16'h1234;
        n = 0;
        acks = 0;
        while (clr_busy && n < 2000) begin
            disp_req  = (n % 2 == 0);
            disp_addr = AW'($urandom_range(200, NW - 1));
            clr_start = (n == 50);
            clr_hires = 1'b1;
            d = disp_req;
            a = disp_addr;
            tick();
            if (cpu_ack) acks++;
            if (d) begin
                checks++; if ({disp_valid, disp_data} !== {1'b1, ref_mem[a]}) $display("FAIL ilv_disp n=%0d: got v=%b d=%0h want 1/%0h", n, disp_valid, disp_data, ref_mem[a]); else passes++;
            end
            n++;
        end
        disp_req = 1'b0;
        clr_start = 1'b0;
        checks++; if (n != 2 * FB_LORES_WORDS) $display("FAIL ilv_busy_len: got %0d want %0d", n, 2 * FB_LORES_WORDS); else passes++;
        checks++; if (acks != 0) $display("FAIL ilv_ack_during_clear: got %0d acks want 0", acks); else passes++;
        tick();
        checks++; if (cpu_ack !== 1'b1) $display("FAIL ilv_ack_after_clear: got %b want 1", cpu_ack); else passes++;
        cpu_req = 1'b0;
        for (int w = 0; w < FB_LORES_WORDS; w++) ref_mem[w] = '0;
        ref_mem[9'h100] = 16'h1234;
        tick();
        checks++; if (clr_busy !== 1'b0) $display("FAIL ilv_restart_ignored: got busy=%b want 0", clr_busy); else passes++;
        checks++; if (mem_mismatches() != 0) $display("FAIL ilv_mem: got %0d bad words want 0", mem_mismatches()); else passes++;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        idle_inputs();
        clr_hires = 1'b1;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        disp_req  = 1'b1;
        disp_addr = 9'd5;
        tick();
        checks++; if ({clr_busy, disp_valid} !== 2'b11) $display("FAIL mid_pre_reset: got busy=%b valid=%b want 1/1", clr_busy, disp_valid); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (clr_busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", clr_busy); else passes++;
        checks++; if (disp_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", disp_valid); else passes++;
        checks++; if (cpu_ack !== 1'b0) $display("FAIL mid_rst_ack: got %b want 0", cpu_ack); else passes++;
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        #1;
        checks++; if ({ram_we, ram_addr} !== {1'b1, AW'(0)}) $display("FAIL mid_restart_addr: got we=%b addr=%0h want 1/0", ram_we, ram_addr); else passes++;
        n = 0;
        while (clr_busy && n < 2000) begin
            n++;
            tick();
        end
        checks++; if (n != FB_LORES_WORDS) $display("FAIL mid_restart_len: got %0d want %0d", n, FB_LORES_WORDS); else passes++;
        n = 0;
        for (int a = 0; a < FB_LORES_WORDS; a++) if (mem[a] !== '0) n++;
        checks++; if (n != 0) $display("FAIL mid_restart_mem: got %0d nonzero words want 0", n); else passes++;
    endtask

    initial begin
        test_reset();
        test_display();
        test_cpu_rw();
        test_conflict();
        test_random_traffic();
        test_clear(1'b0);
        test_clear(1'b1);
        test_clear_interleave();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
